// File: rtl/codinv_thora_pkg.sv
// Shared definitions for the BCD hour-complement encoder.
//   state_e        : FSM encoding (IDLE, SUB_UNI, SUB_DEC, HOLD)
//   BCD_DIGIT_MAX  : largest legal BCD digit
//   *_MAX_*        : maximum-value digits for hour and minute/second use
//   bcd_invalid()  : range check of a two-digit BCD value against a maximum
package thora_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUB_UNI = 2'd1,
        SUB_DEC = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    localparam logic [3:0] HOUR_MAX_DEC = 4'd2;
    localparam logic [3:0] HOUR_MAX_UNI = 4'd3;
    localparam logic [3:0] MIN_MAX_DEC  = 4'd5;
    localparam logic [3:0] MIN_MAX_UNI  = 4'd9;

    // Tens digit decides first; units only matter when the tens digits tie.
    function automatic logic bcd_invalid(input logic [3:0] dec,
                                         input logic [3:0] uni,
                                         input logic [3:0] max_dec,
                                         input logic [3:0] max_uni);
        return (dec > BCD_DIGIT_MAX) | (uni > BCD_DIGIT_MAX) |
               (dec > max_dec) | ((dec == max_dec) & (uni > max_uni));
    endfunction

endpackage

// File: rtl/codinv_thora_bcd_digit_sub.sv
// Combinational single-digit BCD subtract: diff = a - b - bin (mod 10).
//   a, b : BCD digits (minuend, subtrahend)
//   bin  : borrow in
//   diff : BCD result digit
//   bout : borrow out (set when a < b + bin)
module bcd_digit_sub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        bout = raw[4];
        // A negative raw difference wraps into the next decade by adding 10.
        diff = raw[4] ? (raw[3:0] + 4'd10) : raw[3:0];
    end

endmodule

// File: rtl/codinv_thora.sv
// Registered BCD complement encoder: returns MAX - value as a BCD pair.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready high only in IDLE)
//   in_dec, in_uni      : tens / units BCD digits of the input value
//   out_valid/out_ready : result handshake, result held until accepted
//   code_dec, code_uni  : tens / units BCD digits of MAX - value
//   err                 : input out of range; result forced to 00
module codinv_thora
    import thora_pkg::*;
#(
    parameter logic [3:0] MAX_DEC = HOUR_MAX_DEC,
    parameter logic [3:0] MAX_UNI = HOUR_MAX_UNI
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_dec,
    input  logic [3:0] in_uni,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] code_dec,
    output logic [3:0] code_uni,
    output logic       err
);

    state_e     state_q, state_d;
    logic [3:0] dec_q, dec_d;
    logic [3:0] uni_q, uni_d;
    logic       bad_q, bad_d;
    logic       borrow_q, borrow_d;
    logic [3:0] code_dec_q, code_dec_d;
    logic [3:0] code_uni_q, code_uni_d;
    logic       err_q, err_d;
    logic       out_valid_q, out_valid_d;

    logic [3:0] sub_a;
    logic [3:0] sub_b;
    logic       sub_bin;
    logic [3:0] sub_diff;
    logic       sub_bout;

    // One subtractor serves both digits; operands follow the current state.
    always_comb begin
        if (state_q == SUB_DEC) begin
            sub_a   = MAX_DEC;
            sub_b   = dec_q;
            sub_bin = borrow_q;
        end else begin
            sub_a   = MAX_UNI;
            sub_b   = uni_q;
            sub_bin = 1'b0;
        end
    end

    bcd_digit_sub u_sub (
        .a    (sub_a),
        .b    (sub_b),
        .bin  (sub_bin),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        uni_d       = uni_q;
        bad_d       = bad_q;
        borrow_d    = borrow_q;
        code_dec_d  = code_dec_q;
        code_uni_d  = code_uni_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dec_d   = in_dec;
                    uni_d   = in_uni;
                    bad_d   = bcd_invalid(in_dec, in_uni, MAX_DEC, MAX_UNI);
                    state_d = SUB_UNI;
                end
            end
            SUB_UNI: begin
                if (bad_q) begin
                    code_uni_d = '0;
                    borrow_d   = 1'b0;
                end else begin
                    code_uni_d = sub_diff;
                    borrow_d   = sub_bout;
                end
                state_d = SUB_DEC;
            end
            SUB_DEC: begin
                code_dec_d  = bad_q ? '0 : sub_diff;
                err_d       = bad_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dec_q       <= '0;
            uni_q       <= '0;
            bad_q       <= 1'b0;
            borrow_q    <= 1'b0;
            code_dec_q  <= '0;
            code_uni_q  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            uni_q       <= uni_d;
            bad_q       <= bad_d;
            borrow_q    <= borrow_d;
            code_dec_q  <= code_dec_d;
            code_uni_q  <= code_uni_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign code_dec  = code_dec_q;
    assign code_uni  = code_uni_q;
    assign err       = err_q;

endmodule

// File: tb/tb_codinv_thora.sv
// Bench for codinv_thora: an hour instance (MAX 23) and a minute instance
// (MAX 59) share the same stimulus and are checked against their own
// expected-result queues.
module tb_codinv_thora;
    import thora_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_dec;
    logic [3:0] in_uni;

    logic       h_in_ready, h_out_valid, h_err;
    logic [3:0] h_code_dec, h_code_uni;
    logic       m_in_ready, m_out_valid, m_err;
    logic [3:0] m_code_dec, m_code_uni;

    codinv_thora u_hour (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (h_in_ready),
        .in_dec    (in_dec),
        .in_uni    (in_uni),
        .out_valid (h_out_valid),
        .out_ready (out_ready),
        .code_dec  (h_code_dec),
        .code_uni  (h_code_uni),
        .err       (h_err)
    );

    codinv_thora #(
        .MAX_DEC (MIN_MAX_DEC),
        .MAX_UNI (MIN_MAX_UNI)
    ) u_min (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in_dec    (in_dec),
        .in_uni    (in_uni),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .code_dec  (m_code_dec),
        .code_uni  (m_code_uni),
        .err       (m_err)
    );

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] u;
        logic       e;
    } res_t;

    typedef struct {
        logic [3:0] d;
        logic [3:0] u;
        res_t       h;
        res_t       m;
    } vec_t;

    res_t sb_h[$];
    res_t sb_m[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: complement in ordinary integers, then split to BCD.
    function automatic res_t model(input int unsigned mx, input logic [3:0] d, input logic [3:0] u);
        int unsigned dd;
        int unsigned uu;
        int unsigned v;
        int unsigned r;
        dd = int'(d);
        uu = int'(u);
        v  = dd * 10 + uu;
        if (dd > 9 || uu > 9 || v > mx) return '{d: 4'd0, u: 4'd0, e: 1'b1};
        r = mx - v;
        return '{d: 4'(r / 10), u: 4'(r % 10), e: 1'b0};
    endfunction

    function automatic res_t r(input int unsigned d, input int unsigned u, input bit e);
        return '{d: 4'(d), u: 4'(u), e: e};
    endfunction

    // Called #1 after a posedge with both DUTs in IDLE. hold = cycles of
    // backpressure after out_valid rises (0 = out_ready tied high).
    task automatic send(input logic [3:0] d, input logic [3:0] u, input int unsigned hold,
                        input res_t eh, input res_t em);
        int unsigned cyc;
        res_t ph;
        res_t pm;
        in_dec    = d;
        in_uni    = u;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", {15'd0, h_in_ready & m_in_ready}, 16'd1);
        @(posedge clk);
        sb_h.push_back(eh);
        sb_m.push_back(em);
        #1;
        in_valid = 1'b0;
        chk("in_ready_busy", {14'd0, h_in_ready, m_in_ready}, 16'd0);
        cyc = 0;
        while (!h_out_valid && cyc < 6) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 16'(cyc), 16'd2);
        chk("m_out_valid", {15'd0, m_out_valid}, 16'd1);
        ph = sb_h.pop_front();
        pm = sb_m.pop_front();
        chk("hour_result", {7'd0, h_code_dec, h_code_uni, h_err}, {7'd0, ph});
        chk("min_result", {7'd0, m_code_dec, m_code_uni, m_err}, {7'd0, pm});
        for (int i = 0; i < int'(hold); i++) begin
            in_valid = 1'b1;
            in_dec   = 4'($urandom_range(0, 9));
            in_uni   = 4'($urandom_range(0, 9));
            @(posedge clk);
            #1;
            chk("hold_valid", {14'd0, h_out_valid, m_out_valid}, 16'h3);
            chk("hold_ready", {14'd0, h_in_ready, m_in_ready}, 16'h0);
            chk("hold_hour", {7'd0, h_code_dec, h_code_uni, h_err}, {7'd0, ph});
            chk("hold_min", {7'd0, m_code_dec, m_code_uni, m_err}, {7'd0, pm});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", {14'd0, h_out_valid, m_out_valid}, 16'h0);
        chk("release_ready", {14'd0, h_in_ready, m_in_ready}, 16'h3);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{d: 4'h0, u: 4'h0, h: r(2, 3, 0), m: r(5, 9, 0)};
        vecs[1]  = '{d: 4'h0, u: 4'h4, h: r(1, 9, 0), m: r(5, 5, 0)};
        vecs[2]  = '{d: 4'h0, u: 4'h9, h: r(1, 4, 0), m: r(5, 0, 0)};
        vecs[3]  = '{d: 4'h1, u: 4'h3, h: r(1, 0, 0), m: r(4, 6, 0)};
        vecs[4]  = '{d: 4'h1, u: 4'h9, h: r(0, 4, 0), m: r(4, 0, 0)};
        vecs[5]  = '{d: 4'h2, u: 4'h3, h: r(0, 0, 0), m: r(3, 6, 0)};
        vecs[6]  = '{d: 4'h2, u: 4'h4, h: r(0, 0, 1), m: r(3, 5, 0)};
        vecs[7]  = '{d: 4'h1, u: 4'hA, h: r(0, 0, 1), m: r(0, 0, 1)};
        vecs[8]  = '{d: 4'hF, u: 4'h0, h: r(0, 0, 1), m: r(0, 0, 1)};
        vecs[9]  = '{d: 4'h0, u: 4'h7, h: r(1, 6, 0), m: r(5, 2, 0)};
        vecs[10] = '{d: 4'h5, u: 4'h9, h: r(0, 0, 1), m: r(0, 0, 0)};
        vecs[11] = '{d: 4'h6, u: 4'h0, h: r(0, 0, 1), m: r(0, 0, 1)};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_dec    = '0;
        in_uni    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hour", {7'd0, h_code_dec, h_code_uni, h_err}, 16'd0);
        chk("rst_min", {7'd0, m_code_dec, m_code_uni, m_err}, 16'd0);
        chk("rst_valid", {14'd0, h_out_valid, m_out_valid}, 16'd0);
        chk("rst_ready", {14'd0, h_in_ready, m_in_ready}, 16'h3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) send(vecs[i].d, vecs[i].u, 0, vecs[i].h, vecs[i].m);

        // Back-to-back sweep over every legal hour value.
        for (int v = 0; v <= 23; v++) begin
            logic [3:0] d;
            logic [3:0] u;
            d = 4'(v / 10);
            u = 4'(v % 10);
            send(d, u, 0, model(23, d, u), model(59, d, u));
        end

        // Backpressure: 15 held for 10 cycles with in_valid pulses ignored.
        send(4'h1, 4'h5, 10, r(0, 8, 0), r(4, 4, 0));

        // Reset during SUB_DEC of 07 discards the partial result.
        in_dec   = 4'h0;
        in_uni   = 4'h7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_code_uni", {8'd0, h_code_uni, m_code_uni}, 16'h0062);
        reset = 1'b0;
        #1;
        chk("mid_rst_hour", {7'd0, h_code_dec, h_code_uni, h_err}, 16'd0);
        chk("mid_rst_min", {7'd0, m_code_dec, m_code_uni, m_err}, 16'd0);
        chk("mid_rst_valid", {14'd0, h_out_valid, m_out_valid}, 16'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mid_rst_hold", {12'd0, h_out_valid, m_out_valid, h_in_ready, m_in_ready}, 16'h3);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_valid_after_rst", {14'd0, h_out_valid, m_out_valid}, 16'd0);
        end
        send(4'h1, 4'h2, 0, r(1, 1, 0), r(4, 7, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
